// File: rtl/uart_stream_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_stream_pkg : shared types and helpers for the stream merger |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'h30;
  localparam int         MAX_CH           = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_stream_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_stream_arbiter_if : channel inputs, merged output, status   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart_stream_arbiter_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0]   in_valid;
  logic [8*N_CH-1:0] in_data;
  logic              tag_en;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic [N_CH-1:0]   fifo_empty;
  logic [N_CH-1:0]   ovf;
  logic              clr_ovf;
  logic [2:0]        active_ch;

  modport slave (
    input  in_valid, in_data, tag_en, out_ready, clr_ovf,
    output out_valid, out_data, fifo_empty, ovf, active_ch
  );

  modport master (
    output in_valid, in_data, tag_en, out_ready, clr_ovf,
    input  out_valid, out_data, fifo_empty, ovf, active_ch
  );
endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | byte_fifo : per-channel byte FIFO, drop-on-full with ovf pulse   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module byte_fifo
  import uart_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf_set,
  output logic [clog2(DEPTH):0] count
);
  localparam int            AW       = clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          wr_ok, rd_ok;

  // Full is taken from the count at the start of the cycle, so a same-cycle pop never rescues a write.
  always_comb begin
    full     = (count_q == FULL_CNT);
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty_q;
    ovf_set  = wr_en && full;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_stream_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_stream_arbiter : N-channel round-robin burst byte merger    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_stream_arbiter
  import uart_stream_pkg::*;
#(
  parameter int         N_CH     = 2,
  parameter int         DEPTH    = 16,
  parameter int         BURST    = 8,
  parameter logic [7:0] TAG_BASE = TAG_BASE_DEFAULT
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  uart_stream_arbiter_if.slave  bus
);
  localparam int         CW      = clog2(DEPTH) + 1;
  localparam logic [7:0] BURST_B = BURST[7:0];

  state_e            state_q, state_d;
  logic [2:0]        active_q, active_d;
  logic [2:0]        rr_q, rr_d;
  logic [7:0]        burst_q, burst_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;

  logic [7:0]        rd_data_w [MAX_CH];
  logic [CW-1:0]     count_w   [MAX_CH];
  logic [MAX_CH-1:0] empty_w, full_w, in_valid_w;
  logic [N_CH-1:0]   rd_en_w, ovf_set_w;

  logic              out_valid_w, xfer, drains, found;
  logic [7:0]        out_data_w;
  logic [2:0]        grant_ch, next_ch;
  logic [3:0]        idx;

  // Unused slots are padded so the channel mux can be indexed by a 3-bit id.
  for (genvar k = 0; k < MAX_CH; k++) begin : g_ch
    if (k < N_CH) begin : g_fifo
      assign in_valid_w[k] = bus.in_valid[k];
      assign rd_en_w[k]    = xfer && (state_q == DATA) && (active_q == 3'(k));
      byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .wr_en   (in_valid_w[k]),
        .wr_data (bus.in_data[8*k +: 8]),
        .rd_en   (rd_en_w[k]),
        .rd_data (rd_data_w[k]),
        .empty   (empty_w[k]),
        .full    (full_w[k]),
        .ovf_set (ovf_set_w[k]),
        .count   (count_w[k])
      );
    end else begin : g_pad
      assign in_valid_w[k] = 1'b0;
      assign rd_data_w[k]  = 8'h00;
      assign empty_w[k]    = 1'b1;
      assign full_w[k]     = 1'b0;
      assign count_w[k]    = '0;
    end
  end

  // Scan downward so the candidate closest after rr_q is the last one to win.
  always_comb begin
    found    = 1'b0;
    grant_ch = rr_q;
    idx      = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + 4'(i);
      if (idx >= 4'(N_CH)) idx = idx - 4'(N_CH);
      if (!empty_w[idx[2:0]]) begin
        found    = 1'b1;
        grant_ch = idx[2:0];
      end
    end
  end

  always_comb begin
    out_valid_w = 1'b0;
    out_data_w  = 8'h00;
    case (state_q)
      HDR: begin
        out_valid_w = 1'b1;
        out_data_w  = TAG_BASE + {5'b0, active_q};
      end
      DATA: begin
        out_valid_w = !empty_w[active_q];
        out_data_w  = rd_data_w[active_q];
      end
      IDLE:    ;
      default: ;
    endcase
  end

  assign xfer    = out_valid_w && bus.out_ready;
  // A write landing on the last byte keeps the burst alive.
  assign drains  = (count_w[active_q] == CW'(1)) && !(in_valid_w[active_q] && !full_w[active_q]);
  assign next_ch = (active_q == 3'(N_CH - 1)) ? 3'd0 : active_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    rr_d     = rr_q;
    burst_d  = burst_q;
    ovf_d    = (ovf_q & ~{N_CH{bus.clr_ovf}}) | ovf_set_w;
    case (state_q)
      IDLE: begin
        if (found) begin
          active_d = grant_ch;
          burst_d  = 8'd0;
          state_d  = bus.tag_en ? HDR : DATA;
        end
      end
      HDR: begin
        if (xfer) state_d = DATA;
      end
      DATA: begin
        if (xfer) begin
          burst_d = burst_q + 8'd1;
          if ((burst_q + 8'd1 == BURST_B) || drains) begin
            rr_d    = next_ch;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= 3'd0;
      rr_q     <= 3'd0;
      burst_q  <= 8'd0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      rr_q     <= rr_d;
      burst_q  <= burst_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.out_valid  = out_valid_w;
  assign bus.out_data   = out_data_w;
  assign bus.fifo_empty = empty_w[N_CH-1:0];
  assign bus.ovf        = ovf_q;
  assign bus.active_ch  = active_q;

endmodule
`default_nettype wire

// File: doc/uart_stream_arbiter.md
Name: uart_stream_arbiter

Overview:
- Parametrised N-channel byte-stream merger. Replaces the hard-wired single-source UART echo from the ESP8266 link to the PC link.
- Each channel, e.g. the esp8266 rx byte stream or the decoder debug stream, writes into its own FIFO.
- A round-robin arbiter drains the FIFOs in bursts into one byte-wide output that feeds uart_tx.
- Optional tag mode prefixes every burst with a channel-ID byte so the PC side can demultiplex.

Parameters:
- N_CH, 2, number of input channels (1..8).
- DEPTH, 16, per-channel FIFO depth in bytes; power of 2, 4..256.
- BURST, 8, maximum data bytes per grant (1..255).
- TAG_BASE, 8'h30, header byte value for channel 0; channel k sends TAG_BASE+k.

Ports:
- clk_sys  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N_CH  per-channel write strobe, one byte per high cycle.
- in_data  in  8*N_CH  channel k occupies bits [8k+7:8k].
- tag_en  in  1  1 = emit header byte at each burst start; sampled only in IDLE.
- out_valid  out  1  out_data is valid.
- out_data  out  8  byte to transmitter.
- out_ready  in  1  sink accepts; a transfer occurs on a cycle where out_valid and out_ready are both high.
- fifo_empty  out  N_CH  per-channel empty flag.
- ovf  out  N_CH  sticky overflow flag per channel.
- clr_ovf  in  1  one-cycle pulse that clears all ovf bits.
- active_ch  out  3  channel currently granted; holds its last value in IDLE.

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty, pointers and counts 0, state IDLE, out_valid=0, out_data=8'h00, ovf=0, active_ch=0, round-robin pointer=0. Asserting reset mid-burst discards all buffered data immediately.
- FIFO write: in_valid[k]=1 with count_k<DEPTH writes the byte. With count_k==DEPTH the byte is dropped and ovf[k] is set.
- Full is judged on the registered count at the start of the cycle. A simultaneous read from a full FIFO does not rescue the write; it is dropped.
- clr_ovf coinciding with a new overflow on a channel leaves that channel's ovf set; the set wins.
- fifo_empty[k] = (count_k==0), registered.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If any FIFO is non-empty, select the first non-empty channel searching upward from rr_ptr with wrap-around at N_CH-1 to 0.
  - Latch that channel into active_ch and clear burst_cnt.
  - Go to HDR if tag_en, else DATA.
  - If all FIFOs are empty, stay in IDLE.
- HDR: drive out_valid=1, out_data=TAG_BASE+active_ch. On transfer go to DATA.
- DATA:
  - out_data is the FIFO head of active_ch; out_valid=1 while that FIFO is non-empty.
  - On transfer: pop the FIFO and increment burst_cnt.
  - End of burst: after a transfer with burst_cnt+1==BURST, or when the FIFO becomes empty after the pop. Either way set rr_ptr=(active_ch+1) mod N_CH and go to IDLE.
  - A byte written to active_ch during the burst extends the burst, up to BURST bytes.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- out_valid never drops without a transfer, except on reset.
- Latency, tag_en=0, idle block, out_ready=1: a byte written on edge t produces count=1 at t. IDLE grants at edge t+1. out_valid=1 in the cycle after edge t+1.
- Consecutive bytes in one burst transfer back-to-back, one per cycle.
- One idle cycle between bursts (the IDLE state) is allowed.
- FIFO storage: a registered array per channel. Read data comes from a combinational head index.
- Width rules: count_k is clog2(DEPTH)+1 bits. Pointers are clog2(DEPTH) bits and wrap naturally. burst_cnt is 8 bits.

Decomposition:
- Shared package uart_stream_pkg holds:
  - state encoding: IDLE=2'd0, HDR=2'd1, DATA=2'd2;
  - the clog2 function;
  - default TAG_BASE.
- Sub-module byte_fifo, instantiated N_CH times via generate. Parameter DEPTH; ports: clk_sys, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full, ovf_set.
- The top holds the arbiter, the FSM and the ovf registers.

Test Plan:
- Single channel, tag_en=0, N_CH=2: write 8'h41,8'h42,8'h43 on ch0 with out_ready=1 -> out stream 41,42,43. First out_valid occurs 2 cycles after the first write edge. fifo_empty[0]=1 afterwards.
- Tag mode: tag_en=1, ch1 writes 8'h55 -> out stream 8'h31,8'h55. active_ch=1 during the burst.
- Round-robin and BURST: BURST=4; preload 6 bytes on ch0 (00..05) and 2 bytes on ch1 (A0,A1) -> order 00,01,02,03,A0,A1,04,05.
- Backpressure: hold out_ready=0 for 10 cycles mid-burst -> out_data/out_valid unchanged throughout. No byte is lost or duplicated after release.
- Overflow: DEPTH=4, write 6 bytes to ch0 with out_ready=0 -> only the first 4 are retained and ovf[0]=1. clr_ovf clears it. A simultaneous clr_ovf and overflowing write leaves ovf[0]=1.
- Reset mid-burst: assert rst_n=0 during DATA with 3 bytes queued -> out_valid=0 and fifo_empty all 1 immediately, without waiting for a clock. After release, no stale bytes are emitted.
